// File: rtl/traffic_light_pkg.sv
// Shared definitions for the 3-bit one-hot traffic light bus: light codes,
// phase encoding, default phase durations and the legal phase order.
package traffic_light_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    localparam int DEF_RED_CYCLES    = 6;
    localparam int DEF_GREEN_CYCLES  = 6;
    localparam int DEF_YELLOW_CYCLES = 4;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_NONE   = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:    next_phase = PH_GREEN;
            PH_GREEN:  next_phase = PH_YELLOW;
            PH_YELLOW: next_phase = PH_RED;
            default:   next_phase = PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Bus between the light source side (master) and the monitor (slave).
// Carries err_count only when TL_MONITOR_ERRCNT_EN is defined.
interface tl_mon_if #(parameter int CNT_W = 5);
    import traffic_light_pkg::*;

    logic [2:0]       light;
    logic             clr_err;
    phase_t           phase;
    logic             in_sync;
    logic             phase_done;
    logic [CNT_W-1:0] last_dwell;
    logic             err_encoding;
    logic             err_sequence;
    logic             err_duration;
    logic             err_sticky;
`ifdef TL_MONITOR_ERRCNT_EN
    logic [7:0]       err_count;

    modport master (
        output light, clr_err,
        input  phase, in_sync, phase_done, last_dwell,
        input  err_encoding, err_sequence, err_duration, err_sticky, err_count
    );
    modport slave (
        input  light, clr_err,
        output phase, in_sync, phase_done, last_dwell,
        output err_encoding, err_sequence, err_duration, err_sticky, err_count
    );
`else
    modport master (
        output light, clr_err,
        input  phase, in_sync, phase_done, last_dwell,
        input  err_encoding, err_sequence, err_duration, err_sticky
    );
    modport slave (
        input  light, clr_err,
        output phase, in_sync, phase_done, last_dwell,
        output err_encoding, err_sequence, err_duration, err_sticky
    );
`endif

endinterface

// File: rtl/tl_phase_decode.sv
// Combinational decode of the light bus into a phase plus legal/dark flags;
// usable by any consumer of the bus.
module tl_phase_decode
    import traffic_light_pkg::*;
(
    input  logic [2:0] i_light,
    output phase_t     o_phase,
    output logic       o_is_legal,
    output logic       o_is_dark
);

    // Map each one-hot code to its phase; everything else decodes to PH_NONE
    always_comb begin
        o_phase    = PH_NONE;
        o_is_legal = 1'b0;
        o_is_dark  = 1'b0;
        case (i_light)
            LIGHT_RED: begin
                o_phase    = PH_RED;
                o_is_legal = 1'b1;
            end
            LIGHT_GREEN: begin
                o_phase    = PH_GREEN;
                o_is_legal = 1'b1;
            end
            LIGHT_YELLOW: begin
                o_phase    = PH_YELLOW;
                o_is_legal = 1'b1;
            end
            LIGHT_OFF: begin
                o_is_dark  = 1'b1;
            end
            default: begin
                o_phase    = PH_NONE;
            end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic light bus: tracks phase order and dwell,
// flags bad encodings, order and durations. TL_MONITOR_ERRCNT_EN adds err_count.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = DEF_RED_CYCLES,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int CNT_W         = 5
) (
    input  logic     clk,
    input  logic     reset,
    tl_mon_if.slave  bus
);

    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] expected_dwell(input phase_t p);
        case (p)
            PH_RED:    expected_dwell = CNT_W'(RED_CYCLES);
            PH_GREEN:  expected_dwell = CNT_W'(GREEN_CYCLES);
            PH_YELLOW: expected_dwell = CNT_W'(YELLOW_CYCLES);
            default:   expected_dwell = {CNT_W{1'b0}};
        endcase
    endfunction

    phase_t           w_dec;
    logic             w_is_legal;
    logic             w_is_dark;

    phase_t           r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_dwell,      w_dwell_nxt;
    logic             r_partial,    w_partial_nxt;
    logic             r_in_sync;
    logic             r_done,       w_done_nxt;
    logic [CNT_W-1:0] r_last_dwell, w_last_nxt;
    logic             r_err_enc,    w_err_enc;
    logic             r_err_seq,    w_err_seq;
    logic             r_err_dur,    w_err_dur;
    logic             r_sticky,     w_sticky_nxt;
    logic [CNT_W-1:0] w_exp;
    logic             w_any_err;

    tl_phase_decode u_decode (
        .i_light    (bus.light),
        .o_phase    (w_dec),
        .o_is_legal (w_is_legal),
        .o_is_dark  (w_is_dark)
    );

    // Next-state, dwell tracking and error pulse generation
    always_comb begin
        w_state_nxt   = r_state;
        w_dwell_nxt   = r_dwell;
        w_partial_nxt = r_partial;
        w_done_nxt    = 1'b0;
        w_last_nxt    = r_last_dwell;
        w_err_enc     = 1'b0;
        w_err_seq     = 1'b0;
        w_err_dur     = 1'b0;
        w_exp         = expected_dwell(r_state);
        case (r_state)
            PH_NONE: begin
                if (bus.light == LIGHT_RED) begin
                    w_state_nxt   = PH_RED;
                    w_dwell_nxt   = DWELL_ONE;
                    w_partial_nxt = 1'b1;
                end else begin
                    w_err_enc = !(w_is_legal || w_is_dark);
                end
            end
            PH_RED, PH_GREEN, PH_YELLOW: begin
                if (!w_is_legal) begin
                    w_err_enc     = 1'b1;
                    w_state_nxt   = PH_NONE;
                    w_dwell_nxt   = {CNT_W{1'b0}};
                    w_partial_nxt = 1'b0;
                end else if (w_dec == r_state) begin
                    // A stuck phase is flagged once, on the cycle dwell passes expected
                    if (r_dwell != DWELL_MAX) begin
                        w_dwell_nxt = r_dwell + DWELL_ONE;
                        w_err_dur   = (r_dwell == w_exp);
                    end else begin
                        w_dwell_nxt = r_dwell;
                    end
                end else begin
                    w_done_nxt    = 1'b1;
                    w_last_nxt    = r_dwell;
                    w_err_dur     = (r_dwell < w_exp) && !r_partial;
                    w_err_seq     = (w_dec != next_phase(r_state));
                    w_state_nxt   = w_dec;
                    w_dwell_nxt   = DWELL_ONE;
                    w_partial_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = PH_NONE;
                w_dwell_nxt   = {CNT_W{1'b0}};
                w_partial_nxt = 1'b0;
            end
        endcase

        w_any_err = w_err_enc | w_err_seq | w_err_dur;
        if (w_any_err) begin
            w_sticky_nxt = 1'b1;
        end else if (bus.clr_err) begin
            w_sticky_nxt = 1'b0;
        end else begin
            w_sticky_nxt = r_sticky;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= PH_NONE;
            r_dwell      <= {CNT_W{1'b0}};
            r_partial    <= 1'b0;
            r_in_sync    <= 1'b0;
            r_done       <= 1'b0;
            r_last_dwell <= {CNT_W{1'b0}};
            r_err_enc    <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_dur    <= 1'b0;
            r_sticky     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dwell      <= w_dwell_nxt;
            r_partial    <= w_partial_nxt;
            r_in_sync    <= (w_state_nxt != PH_NONE);
            r_done       <= w_done_nxt;
            r_last_dwell <= w_last_nxt;
            r_err_enc    <= w_err_enc;
            r_err_seq    <= w_err_seq;
            r_err_dur    <= w_err_dur;
            r_sticky     <= w_sticky_nxt;
        end
    end

    assign bus.phase        = r_state;
    assign bus.in_sync      = r_in_sync;
    assign bus.phase_done   = r_done;
    assign bus.last_dwell   = r_last_dwell;
    assign bus.err_encoding = r_err_enc;
    assign bus.err_sequence = r_err_seq;
    assign bus.err_duration = r_err_dur;
    assign bus.err_sticky   = r_sticky;

`ifdef TL_MONITOR_ERRCNT_EN
    logic [7:0] r_err_cnt, w_err_cnt_nxt;

    // Saturating count of error cycles; an error coincident with clear counts as 1
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (bus.clr_err) begin
            w_err_cnt_nxt = w_any_err ? 8'd1 : 8'd0;
        end else if (w_any_err && (r_err_cnt != 8'd255)) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
        end else begin
            w_err_cnt_nxt = r_err_cnt;
        end
    end

    // Error counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else begin
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign bus.err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a reference model pushes expected
// outputs per driven cycle, popped and compared one edge later.
module tb_traffic_light_monitor;
    import traffic_light_pkg::*;

    localparam int CW = 5;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    tl_mon_if #(.CNT_W(CW)) bus ();

    traffic_light_monitor #(
        .RED_CYCLES    (6),
        .GREEN_CYCLES  (6),
        .YELLOW_CYCLES (4),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int phase;
        bit in_sync;
        bit done;
        int last;
        bit enc;
        bit seq;
        bit dur;
        bit sticky;
        int cnt;
    } exp_t;

    exp_t sb_q[$];

    int m_state;
    int m_dwell;
    bit m_partial;
    int m_last;
    bit m_sticky;
    int m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_len(input int st);
        case (st)
            0: return 6;
            1: return 6;
            2: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 3; m_dwell = 0; m_partial = 0; m_last = 0; m_sticky = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [2:0] code, input bit clr);
        exp_t e;
        bit lg;
        int q;
        bit enc, seq, dur, done, any;
        enc = 0; seq = 0; dur = 0; done = 0;
        lg = (code == 3'b100) || (code == 3'b001) || (code == 3'b010);
        q  = (code == 3'b100) ? 0 : (code == 3'b001) ? 1 : (code == 3'b010) ? 2 : 3;
        if (m_state == 3) begin
            if (code == 3'b100) begin
                m_state = 0; m_dwell = 1; m_partial = 1;
            end else if (!(lg || code == 3'b000)) begin
                enc = 1;
            end
        end else if (!lg) begin
            enc = 1; m_state = 3; m_dwell = 0; m_partial = 0;
        end else if (q == m_state) begin
            if (m_dwell < 31) begin
                m_dwell++;
                if (m_dwell == exp_len(m_state) + 1) dur = 1;
            end
        end else begin
            done = 1;
            m_last = m_dwell;
            if (m_dwell < exp_len(m_state) && !m_partial) dur = 1;
            if (q != (m_state + 1) % 3) seq = 1;
            m_state = q; m_dwell = 1; m_partial = 0;
        end
        any = enc | seq | dur;
        if (any) m_sticky = 1;
        else if (clr) m_sticky = 0;
        if (clr) m_cnt = any ? 1 : 0;
        else if (any && m_cnt < 255) m_cnt++;
        e.phase = m_state; e.in_sync = (m_state != 3); e.done = done; e.last = m_last;
        e.enc = enc; e.seq = seq; e.dur = dur; e.sticky = m_sticky; e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("phase",      32'(bus.phase),        32'(e.phase));
            check_eq("in_sync",    32'(bus.in_sync),      32'(e.in_sync));
            check_eq("phase_done", 32'(bus.phase_done),   32'(e.done));
            check_eq("last_dwell", 32'(bus.last_dwell),   32'(e.last));
            check_eq("err_enc",    32'(bus.err_encoding), 32'(e.enc));
            check_eq("err_seq",    32'(bus.err_sequence), 32'(e.seq));
            check_eq("err_dur",    32'(bus.err_duration), 32'(e.dur));
            check_eq("err_sticky", 32'(bus.err_sticky),   32'(e.sticky));
`ifdef TL_MONITOR_ERRCNT_EN
            check_eq("err_count",  32'(bus.err_count),    32'(e.cnt));
`endif
        end
    endtask

    task automatic step(input logic [2:0] code, input bit clr);
        @(negedge clk);
        bus.light   = code;
        bus.clr_err = clr;
        model_step(code, clr);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic hold(input logic [2:0] code, input int n);
        for (int i = 0; i < n; i++) step(code, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_phase"},   32'(bus.phase),        32'd3);
        check_eq({tag, "_in_sync"}, 32'(bus.in_sync),      32'd0);
        check_eq({tag, "_done"},    32'(bus.phase_done),   32'd0);
        check_eq({tag, "_last"},    32'(bus.last_dwell),   32'd0);
        check_eq({tag, "_errs"},    32'({bus.err_encoding, bus.err_sequence, bus.err_duration}), 32'd0);
        check_eq({tag, "_sticky"},  32'(bus.err_sticky),   32'd0);
`ifdef TL_MONITOR_ERRCNT_EN
        check_eq({tag, "_cnt"},     32'(bus.err_count),    32'd0);
`endif
    endtask

    initial begin
        logic [2:0] legal [3];
        logic [2:0] code;
        int r;
        legal[0] = 3'b100; legal[1] = 3'b001; legal[2] = 3'b010;
        n_total = 0;
        n_bad   = 0;
        reset       = 1'b1;
        bus.light   = 3'b000;
        bus.clr_err = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Three clean cycles of the full sequence
        for (int k = 0; k < 3; k++) begin
            hold(3'b100, 6);
            hold(3'b001, 6);
            hold(3'b010, 4);
        end
        check_eq("clean_sticky", 32'(bus.err_sticky), 32'd0);

        // Short GREEN
        hold(3'b100, 6);
        hold(3'b001, 5);
        step(3'b010, 1'b0);
        check_eq("short_dwell", 32'(bus.last_dwell),   32'd5);
        check_eq("short_dur",   32'(bus.err_duration), 32'd1);
        check_eq("short_stk",   32'(bus.err_sticky),   32'd1);

        // Long YELLOW: seven samples total, then RED
        hold(3'b010, 3);
        check_eq("long_pre",  32'(bus.err_duration), 32'd0);
        step(3'b010, 1'b0);
        check_eq("long_dur",  32'(bus.err_duration), 32'd1);
        hold(3'b010, 2);
        step(3'b100, 1'b0);
        check_eq("long_last", 32'(bus.last_dwell),   32'd7);
        check_eq("long_nodup", 32'(bus.err_duration), 32'd0);

        // Non-one-hot code while in sync, then resync on RED
        hold(3'b100, 2);
        step(3'b110, 1'b0);
        check_eq("enc_sync", 32'(bus.in_sync),      32'd0);
        check_eq("enc_pls",  32'(bus.err_encoding), 32'd1);
        step(3'b100, 1'b0);
        check_eq("resync",   32'(bus.in_sync),      32'd1);

        // Out-of-order RED->YELLOW, then sticky clear behaviour
        hold(3'b100, 5);
        step(3'b010, 1'b0);
        check_eq("seq_pls",   32'(bus.err_sequence), 32'd1);
        check_eq("seq_phase", 32'(bus.phase),        32'd2);
        step(3'b010, 1'b1);
        check_eq("clr_ok",    32'(bus.err_sticky),   32'd0);
        step(3'b111, 1'b1);
        check_eq("clr_vs_err", 32'(bus.err_sticky),  32'd1);

        // Reset mid-GREEN at dwell 3, then GREEN ignored until RED
        hold(3'b100, 6);
        hold(3'b001, 3);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        hold(3'b001, 3);
        check_eq("post_rst_idle", 32'(bus.phase), 32'd3);
        step(3'b100, 1'b0);

        // Mixed random traffic, mostly legal codes
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                code = legal[r % 3];
            end else begin
                code = 3'($urandom_range(0, 7));
            end
            hold(code, $urandom_range(1, 7));
            if ($urandom_range(0, 7) == 0) step(code, 1'b1);
        end

        check_eq("sb_left", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Receive-side checker for the 3-bit one-hot traffic light bus driven by the intersection controller. Decodes the light code each clock, tracks the phase sequence and dwell time per phase, and flags illegal encodings, out-of-order transitions and wrong phase durations. Sits beside the controller, or at the lamp-driver end of the bus, as a safety/verification monitor; outputs feed the fault-handling logic.

Parameters:
RED_CYCLES, 6, required dwell of RED in clk cycles
GREEN_CYCLES, 6, required dwell of GREEN in clk cycles
YELLOW_CYCLES, 4, required dwell of YELLOW in clk cycles
CNT_W, 5, dwell counter width; must hold max(*_CYCLES)+1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
light  in  3  light bus: 100 RED, 001 GREEN, 010 YELLOW, 000 dark
clr_err  in  1  synchronous clear of err_sticky
phase  out  2  decoded current phase: 0 RED, 1 GREEN, 2 YELLOW, 3 none/IDLE
in_sync  out  1  monitor locked onto sequence (state != IDLE)
phase_done  out  1  1-cycle pulse when a phase ends on a legal code change
last_dwell  out  CNT_W  measured dwell of the phase just ended; valid with phase_done, held otherwise
err_encoding  out  1  1-cycle pulse: illegal or dark code while in sync
err_sequence  out  1  1-cycle pulse: legal but out-of-order transition
err_duration  out  1  1-cycle pulse: phase too short or too long
err_sticky  out  1  OR of all error pulses, held until clr_err or reset

Behaviour:
- Clock/reset: clk, reset asynchronous active-high. All outputs registered. Reset values: phase=3, in_sync=0, phase_done=0, last_dwell=0, all err_*=0, dwell=0, state IDLE.
- Latency: light sampled at edge k; outputs reflecting that sample valid after edge k (one registered stage).
- States: IDLE, RED, GREEN, YELLOW. Legal successor order RED->GREEN->YELLOW->RED.
- IDLE: 000, 001, 010 ignored (no errors). Other codes except 100 -> err_encoding pulse, stay IDLE. 100 -> RED, dwell=1, in_sync=1. First RED after IDLE not duration-checked on short exit (partial phase).
- In phase P, same code: dwell increments, saturates at 2^CNT_W-1. When dwell reaches expected(P)+1 -> err_duration pulse once (stuck phase).
- In phase P, legal code Q != P: phase_done=1, last_dwell=dwell; if dwell<expected(P) -> err_duration (unless P is the initial partial RED); long phase already flagged, not re-flagged. If Q is not successor(P) -> err_sequence; move to Q regardless (resync). dwell=1.
- In phase, code 000 or any non-one-hot code (011,101,110,111) -> err_encoding, go IDLE, in_sync=0, phase=3, dwell=0; no phase_done.
- Multiple error pulses in the same cycle allowed (e.g. short + out-of-order).
- err_sticky: set on any err pulse; cleared by clr_err; new error in same cycle as clr_err wins (stays 1).
- Reset mid-phase: immediate return to reset values; no pulses on exit.

Optional Feature:
TL_MONITOR_ERRCNT_EN: when defined, adds output err_count [7:0]: counts cycles with at least one err_* pulse, saturates at 255, cleared by reset and clr_err (error in same cycle as clr_err -> count=1). When undefined, port and counter absent; all other behaviour identical.

Decomposition:
- Shared package traffic_light_pkg: light codes LIGHT_RED=3'b100, LIGHT_GREEN=3'b001, LIGHT_YELLOW=3'b010, LIGHT_OFF=3'b000; phase encoding typedef (RED/GREEN/YELLOW/NONE); default durations 6/6/4. Controller and monitor both import it.
- One sub-module: tl_phase_decode (combinational light -> phase, is_legal, is_dark), reusable by other bus consumers.

Test Plan:
- Reset, then RED x6, GREEN x6, YELLOW x4 repeated 3 times -> phase_done with last_dwell 6,6,4 each loop; no err_*; err_sticky=0.
- GREEN held 5 cycles then YELLOW -> err_duration and phase_done with last_dwell=5 after first YELLOW sample; err_sticky=1.
- YELLOW held 7 cycles -> err_duration pulse after 5th YELLOW sample only; at exit, phase_done last_dwell=7, no second err_duration.
- In sync, light=110 -> err_encoding, in_sync=0, phase=3; then 100 -> RED, in_sync=1, no error.
- RED x6 then YELLOW -> err_sequence, phase=2, no err_duration; assert clr_err next cycle with no error -> err_sticky=0; clr_err coincident with error -> err_sticky=1.
- Assert reset mid-GREEN (dwell=3) -> all outputs reset value immediately; light 001 afterwards ignored until 100 seen.
